// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EX/WB destination scoreboard, load-use and RAW stalls, branch flush.
// Define HAZARD_CTRL_FORWARD_EN to compile in operand forwarding (EX -> 01, WB -> 10).
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_write,
  input  logic        id_mem_to_reg,
  input  logic        ex_branch_taken,
  output logic        stall,
  output logic        flush,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [15:0] stall_cnt
);

  logic       ex_valid;
  logic [4:0] ex_rd;
  logic       ex_load;
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic       wb_load;
  logic       flush_d1;

  logic ex_writer;
  logic wb_writer;
  logic a_ex;
  logic a_wb;
  logic b_ex;
  logic b_wb;
  logic branch_fire;
  logic raw_stall;

  // Nothing downstream of WB needs to know whether the producer was a load.
  logic unused_wb_load;
  assign unused_wb_load = wb_load;

  always_comb begin
    ex_writer = ex_valid && (ex_rd != 5'd0);
    wb_writer = wb_valid && (wb_rd != 5'd0);
    a_ex = id_use_rs1 && (id_rs1 != 5'd0) && ex_writer && (id_rs1 == ex_rd);
    a_wb = id_use_rs1 && (id_rs1 != 5'd0) && wb_writer && (id_rs1 == wb_rd);
    b_ex = id_use_rs2 && (id_rs2 != 5'd0) && ex_writer && (id_rs2 == ex_rd);
    b_wb = id_use_rs2 && (id_rs2 != 5'd0) && wb_writer && (id_rs2 == wb_rd);
  end

  // A second taken branch arriving during the trailing flush cycle is the killed instruction.
  always_comb begin
    branch_fire = ex_branch_taken && ex_valid && !flush_d1;
    flush       = branch_fire || flush_d1;
  end

`ifdef HAZARD_CTRL_FORWARD_EN
  always_comb begin
    raw_stall = (a_ex && ex_load) || (b_ex && ex_load);
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (a_ex) begin
      fwd_a = ex_load ? 2'b00 : 2'b01;
    end else if (a_wb) begin
      fwd_a = 2'b10;
    end
    if (b_ex) begin
      fwd_b = ex_load ? 2'b00 : 2'b01;
    end else if (b_wb) begin
      fwd_b = 2'b10;
    end
  end
`else
  always_comb begin
    raw_stall = a_ex || a_wb || b_ex || b_wb;
    fwd_a = 2'b00;
    fwd_b = 2'b00;
  end
`endif

  assign stall = raw_stall && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_rd     <= 5'd0;
      ex_load   <= 1'b0;
      wb_valid  <= 1'b0;
      wb_rd     <= 5'd0;
      wb_load   <= 1'b0;
      flush_d1  <= 1'b0;
      stall_cnt <= 16'd0;
    end else begin
      if (stall || flush) begin
        ex_valid <= 1'b0;
        ex_rd    <= 5'd0;
        ex_load  <= 1'b0;
      end else begin
        ex_valid <= id_valid && id_reg_write;
        ex_rd    <= id_rd;
        ex_load  <= id_mem_to_reg;
      end
      wb_valid <= ex_valid;
      wb_rd    <= ex_rd;
      wb_load  <= ex_load;
      flush_d1 <= branch_fire;
      if (stall && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; expectations follow HAZARD_CTRL_FORWARD_EN when defined.
module tb_hazard_ctrl;

`ifdef HAZARD_CTRL_FORWARD_EN
  localparam bit FWD = 1'b1;
  localparam int PERIOD = 2;
  localparam int STALLS_PER = 1;
`else
  localparam bit FWD = 1'b0;
  localparam int PERIOD = 3;
  localparam int STALLS_PER = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [4:0]  id_rd;
  logic        id_reg_write;
  logic        id_mem_to_reg;
  logic        ex_branch_taken;
  logic        stall;
  logic        flush;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic [15:0] stall_cnt;

  int errors = 0;
  int checks = 0;
  logic [15:0] base_cnt;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
    .ex_branch_taken(ex_branch_taken), .stall(stall), .flush(flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
  );

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic [4:0] rd,
                               input logic wr, input logic ld, input logic br);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_reg_write = wr; id_mem_to_reg = ld; ex_branch_taken = br;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    #1;
    checkOutput("rst_stall", 16'(stall), 16'd0);
    checkOutput("rst_flush", 16'(flush), 16'd0);
    checkOutput("rst_fwd_a", 16'(fwd_a), 16'd0);
    checkOutput("rst_fwd_b", 16'(fwd_b), 16'd0);
    checkOutput("rst_cnt", stall_cnt, 16'd0);

    // x5 writer followed by a reader of rs1=x5, reader held for three cycles
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    checkOutput("s1_writer_stall", 16'(stall), 16'd0);
    tick();
    applyStimulus(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("s1_c1_stall", 16'(stall), FWD ? 16'd0 : 16'd1);
    checkOutput("s1_c1_fwd_a", 16'(fwd_a), FWD ? 16'd1 : 16'd0);
    tick();
    checkOutput("s1_c2_stall", 16'(stall), FWD ? 16'd0 : 16'd1);
    checkOutput("s1_c2_fwd_a", 16'(fwd_a), FWD ? 16'd2 : 16'd0);
    checkOutput("s1_c2_cnt", stall_cnt, FWD ? 16'd0 : 16'd1);
    tick();
    checkOutput("s1_c3_stall", 16'(stall), 16'd0);
    checkOutput("s1_c3_fwd_a", 16'(fwd_a), 16'd0);
    checkOutput("s1_c3_cnt", stall_cnt, FWD ? 16'd0 : 16'd2);
    base_cnt = FWD ? 16'd0 : 16'd2;

    // x0 is never a hazard
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("s2_stall", 16'(stall), 16'd0);
    checkOutput("s2_fwd_a", 16'(fwd_a), 16'd0);
    checkOutput("s2_fwd_b", 16'(fwd_b), 16'd0);
    tick();
    checkOutput("s2_cnt", stall_cnt, base_cnt);

`ifdef HAZARD_CTRL_FORWARD_EN
    // ALU result forwarded from EX then from WB
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("s3_fwd_b_ex", 16'(fwd_b), 16'd1);
    checkOutput("s3_fwd_a", 16'(fwd_a), 16'd0);
    checkOutput("s3_stall", 16'(stall), 16'd0);
    tick();
    checkOutput("s3_fwd_b_wb", 16'(fwd_b), 16'd2);
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    applyStimulus(1'b1, 5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("s3_ex_priority", 16'(fwd_b), 16'd1);
    tick();

    // load-use: one stall, then WB forward
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("s4_c1_stall", 16'(stall), 16'd1);
    tick();
    checkOutput("s4_c2_stall", 16'(stall), 16'd0);
    checkOutput("s4_c2_fwd_a", 16'(fwd_a), 16'd2);
    checkOutput("s4_c2_cnt", stall_cnt, base_cnt + 16'd1);
    base_cnt = base_cnt + 16'd1;
`endif

    // taken branch in EX (a writer of x9) while ID holds a hazard on x9
    idle();
    tick();
    tick();
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1);
    checkOutput("s5_c1_flush", 16'(flush), 16'd1);
    checkOutput("s5_c1_stall", 16'(stall), 16'd0);
    tick();
    checkOutput("s5_c2_flush", 16'(flush), 16'd1);
    checkOutput("s5_c2_stall", 16'(stall), 16'd0);
    tick();
    applyStimulus(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("s5_c3_flush", 16'(flush), 16'd0);
    checkOutput("s5_c3_stall", 16'(stall), 16'd0);
    checkOutput("s5_cnt", stall_cnt, base_cnt);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("s5_empty_ex_flush", 16'(flush), 16'd0);
    tick();
    idle();
    checkOutput("s5_empty_ex_d1", 16'(flush), 16'd0);

    // reset asserted in the middle of a load-use stall
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("s6_pre_stall", 16'(stall), 16'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checkOutput("s6_stall", 16'(stall), 16'd0);
    checkOutput("s6_flush", 16'(flush), 16'd0);
    checkOutput("s6_cnt", stall_cnt, 16'd0);

    // self-dependent load to x5 held in ID stalls on a fixed repeating pattern
    applyStimulus(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < (65534 / STALLS_PER) * PERIOD; i++) @(posedge clk);
    #1;
    checkOutput("s7_cnt_fffe", stall_cnt, 16'hFFFE);
    for (int i = 0; i < (6 / STALLS_PER) * PERIOD; i++) @(posedge clk);
    #1;
    checkOutput("s7_cnt_sat", stall_cnt, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The ports SHALL be as follows, listed as name, direction, width, meaning:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- id_valid  in  1  decode stage holds a real instruction.
- id_rs1  in  5  source register 1 index of the decode instruction.
- id_rs2  in  5  source register 2 index of the decode instruction.
- id_use_rs1  in  1  decode instruction reads rs1.
- id_use_rs2  in  1  decode instruction reads rs2.
- id_rd  in  5  destination register index of the decode instruction.
- id_reg_write  in  1  decode instruction writes rd.
- id_mem_to_reg  in  1  decode instruction is a load.
- ex_branch_taken  in  1  branch or jump resolved taken in EX.
- stall  out  1  hold PC and decode register; insert bubble into EX.
- flush  out  1  kill the decode instruction.
- fwd_a  out  2  rs1 operand source: 00 regfile, 01 EX result, 10 WB result.
- fwd_b  out  2  rs2 operand source, same encoding as fwd_a.
- stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-003 The block SHALL hold a two-entry scoreboard, EX slot and WB slot, each holding {valid, rd[4:0], is_load}.
REQ-004 An entry SHALL count as a writer only when valid=1 and rd!=0.
REQ-005 A source SHALL match an entry when its use bit=1, its index!=0, and its index equals the entry rd with the entry a writer.
REQ-006 On each edge with no stall and no flush, EX SHALL load {id_valid & id_reg_write, id_rd, id_mem_to_reg}.
REQ-007 On each edge with stall or flush, EX SHALL load a bubble (valid=0).
REQ-008 On every edge, WB SHALL load the previous EX contents.
REQ-009 The EX slot SHALL be updated from a branch-taken EX instruction normally; the branch SHALL not be cancelled.
REQ-010 flush SHALL equal (ex_branch_taken AND EX.valid) OR flush_d1, where flush_d1 is ex_branch_taken registered.
REQ-011 Flush SHALL therefore cover exactly two consecutive cycles: the instructions in ID and in IF at resolution.
REQ-012 ex_branch_taken SHALL be ignored while flush_d1=1.
REQ-013 Without forwarding, stall SHALL be 1 when either source matches EX or WB, and flush=0.
REQ-014 flush SHALL override stall: stall SHALL be forced to 0 while flush=1.
REQ-015 stall, flush, fwd_a and fwd_b SHALL be combinational from the inputs and state, with zero-cycle latency.
REQ-016 stall_cnt SHALL increment by 1 on each edge where stall=1.
REQ-017 stall_cnt SHALL saturate at 16'hFFFF and not wrap.

Reset
REQ-018 While rst=1 at an edge, both slots SHALL be cleared to valid=0.
REQ-019 While rst=1 at an edge, flush_d1 and stall_cnt SHALL be cleared to 0.
REQ-020 After that edge, stall=0, flush=0, fwd_a=00 and fwd_b=00.
REQ-021 Reset SHALL take priority over every simultaneous event, including a reset asserted during a stall or flush sequence.

Configuration
REQ-022 Forwarding SHALL be compiled in only when macro HAZARD_CTRL_FORWARD_EN is defined.
REQ-023 Without the macro, fwd_a and fwd_b SHALL be constant 00, and REQ-013 governs stall.
REQ-024 With the macro, a source matching EX with is_load=0 SHALL select 01.
REQ-025 With the macro, a source matching only WB SHALL select 10.
REQ-026 With the macro, when a source matches both slots, EX SHALL take priority.
REQ-027 With the macro, stall SHALL be 1 only when a source matches an EX entry with is_load=1, subject to REQ-014.

Verification
REQ-028 The bench SHALL cover each of the following directed scenarios, and SHALL run the non-forwarding scenarios with and without the macro:
- No macro: writer of x5, then a reader of rs1=x5 -> stall=1 for 2 cycles, stall_cnt=2, then stall=0.
- No macro: writer of x0, then a reader of x0 -> stall=0 and no bubble.
- Macro: ALU writer of x7, then a reader of rs2=x7 -> fwd_b=01 and stall=0; the next reader of x7 gets fwd_b=10.
- Macro: load to x3, then a reader of rs1=x3 -> stall=1 for 1 cycle, then fwd_a=10.
- Taken branch in EX with a hazard present in ID -> flush=1 for 2 cycles, stall=0, EX bubbles, stall_cnt unchanged.
- Reset asserted mid-stall -> next cycle stall=0, flush=0, stall_cnt=0.
- Force 65540 stall cycles -> stall_cnt holds 16'hFFFF.
